// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: configurable controller around a Moore 4-bit serial sequence
// detector. The pattern, overlap mode and match limit are loaded through a
// ready/valid port while the controller is idle. Each run shifts qualified
// serial bits into a history register, flags every match for one cycle,
// counts matches and stops once the limit is reached.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   cfg_valid / cfg_ready    config handshake (ready only while idle)
//   cfg_pattern[3:0]         target sequence, MSB = oldest bit
//   cfg_overlap              1 = overlapping matches allowed
//   cfg_limit[7:0]           matches before DONE, 0 = unlimited
//   start, abort             run control (abort has priority)
//   in, in_valid             serial data bit and its qualifier
//   out                      one-cycle match flag
//   match_cnt[7:0]           matches in the current run, saturating
//   busy, done               run in progress / run finished
module seq_det_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_pattern,
  input  logic       cfg_overlap,
  input  logic [7:0] cfg_limit,
  input  logic       start,
  input  logic       abort,
  input  logic       in,
  input  logic       in_valid,
  output logic       out,
  output logic [7:0] match_cnt,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] pattern;
  logic       overlap;
  logic [7:0] limit;
  logic [3:0] hist;
  logic [2:0] fill;

  logic [3:0] hist_nxt;
  logic [2:0] fill_inc;
  logic [7:0] cnt_inc;
  logic       hit;

  // Status flags decode straight from the state register, so they change
  // only on the clock edge.
  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  // Candidate history/fill after accepting the current bit; a match is
  // judged on these updated values so out rises the cycle after the bit.
  always_comb begin
    hist_nxt = {hist[2:0], in};
    fill_inc = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    hit      = (fill_inc == 3'd4) && (hist_nxt == pattern);
    cnt_inc  = (match_cnt == '1) ? match_cnt : match_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pattern   <= 4'b1011;
      overlap   <= 1'b1;
      limit     <= '0;
      hist      <= '0;
      fill      <= '0;
      out       <= 1'b0;
      match_cnt <= '0;
    end else begin
      out <= 1'b0;

      // A same-cycle start already sees these values on its first bit.
      if (cfg_valid && (state == IDLE)) begin
        pattern <= cfg_pattern;
        overlap <= cfg_overlap;
        limit   <= cfg_limit;
      end

      case (state)
        IDLE: begin
          if (!abort && start) begin
            state     <= RUN;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
          end
        end
        RUN: begin
          // abort wins over a match on the same bit: nothing is recorded.
          if (abort) begin
            state <= IDLE;
          end else if (in_valid) begin
            hist <= hist_nxt;
            fill <= (hit && !overlap) ? 3'd0 : fill_inc;
            if (hit) begin
              out       <= 1'b1;
              match_cnt <= cnt_inc;
              if ((limit != '0) && (cnt_inc == limit)) state <= DONE;
            end
          end
        end
        DONE: begin
          if (abort) begin
            state <= IDLE;
          end else if (start) begin
            state     <= RUN;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Testbench for seq_det_ctrl: directed scenarios with literal expectations,
// then randomized traffic. Every cycle all outputs are compared against a
// behavioural model that keeps the accepted bits of the current run in a
// queue and decides matches from the last four of them.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst, cfg_valid, cfg_overlap, start, abort, in, in_valid;
  logic [3:0] cfg_pattern;
  logic [7:0] cfg_limit;
  logic       cfg_ready, out, busy, done;
  logic [7:0] match_cnt;

  int n_vec = 0;
  int n_err = 0;

  // model: 0 = idle, 1 = running, 2 = finished
  int       m_state;
  bit [3:0] m_pat;
  bit       m_ovl;
  int       m_lim;
  bit       hq[$];
  int       m_cnt;
  bit       m_out;

  seq_det_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
    .start(start), .abort(abort), .in(in), .in_valid(in_valid),
    .out(out), .match_cnt(match_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_state = 0; m_pat = 4'b1011; m_ovl = 1'b1; m_lim = 0;
    hq.delete(); m_cnt = 0; m_out = 1'b0;
  endfunction

  function automatic void begin_run();
    m_state = 1; hq.delete(); m_cnt = 0;
  endfunction

  // One clock edge of the specified behaviour, using the inputs now applied.
  function automatic void model_step();
    int v;
    if (rst) begin
      model_reset();
      return;
    end
    m_out = 1'b0;
    if (cfg_valid && m_state == 0) begin
      m_pat = cfg_pattern; m_ovl = cfg_overlap; m_lim = int'(cfg_limit);
    end
    case (m_state)
      0: if (!abort && start) begin_run();
      1: begin
        if (abort) m_state = 0;
        else if (in_valid) begin
          hq.push_back(in);
          if (hq.size() > 4) void'(hq.pop_front());
          v = 0;
          foreach (hq[i]) v = v * 2 + int'(hq[i]);
          if (hq.size() == 4 && v == int'(m_pat)) begin
            m_out = 1'b1;
            if (m_cnt < 255) m_cnt++;
            if (!m_ovl) hq.delete();
            if (m_lim != 0 && m_cnt == m_lim) m_state = 2;
          end
        end
      end
      default: begin
        if (abort) m_state = 0;
        else if (start) begin_run();
      end
    endcase
  endfunction

  function automatic void check(string name, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void check_all();
    check("out", int'(out), int'(m_out));
    check("match_cnt", int'(match_cnt), m_cnt);
    check("busy", int'(busy), int'(m_state == 1));
    check("done", int'(done), int'(m_state == 2));
    check("cfg_ready", int'(cfg_ready), int'(m_state == 0));
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic quiet();
    rst = 1'b0; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    in = 1'b0; in_valid = 1'b0;
  endtask

  task automatic bit_in(input logic b, input logic ab);
    in = b; in_valid = 1'b1; abort = ab;
    cycle();
    in_valid = 1'b0; abort = 1'b0;
  endtask

  // n bits of v, MSB first
  task automatic stream(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(v[i], 1'b0);
  endtask

  task automatic configure(input logic [3:0] p, input logic o, input logic [7:0] l,
                           input logic st);
    cfg_valid = 1'b1; cfg_pattern = p; cfg_overlap = o; cfg_limit = l; start = st;
    cycle();
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1; cycle(); abort = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  initial begin
    quiet();
    cfg_pattern = '0; cfg_overlap = 1'b0; cfg_limit = '0;
    model_reset();
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    check("rst_out", int'(out), 0);
    check("rst_cnt", int'(match_cnt), 0);
    check("rst_ready", int'(cfg_ready), 1);

    // default pattern 1011 with overlap: pulses after bits 4 and 7
    do_start();
    check("t1_busy", int'(busy), 1);
    stream(16'b1011, 4);
    check("t1_out4", int'(out), 1);
    stream(16'b011, 3);
    check("t1_out7", int'(out), 1);
    check("t1_cnt", int'(match_cnt), 2);
    check("t1_done", int'(done), 0);

    // no overlap: single pulse
    do_abort();
    configure(4'b1011, 1'b0, 8'd0, 1'b0);
    do_start();
    stream(16'b1011, 4);
    check("t2_out4", int'(out), 1);
    stream(16'b011, 3);
    check("t2_out7", int'(out), 0);
    check("t2_cnt", int'(match_cnt), 1);

    // limit 2: DONE after bit 8, further bits ignored, restart clears count
    do_abort();
    configure(4'b1011, 1'b1, 8'd2, 1'b1);
    stream(16'b1011_1011, 8);
    check("t3_out8", int'(out), 1);
    check("t3_done", int'(done), 1);
    check("t3_busy", int'(busy), 0);
    check("t3_cnt", int'(match_cnt), 2);
    stream(16'b1011, 4);
    check("t3_hold", int'(match_cnt), 2);
    check("t3_hold_out", int'(out), 0);
    do_start();
    check("t3_restart", int'(match_cnt), 0);

    // gaps between valid bits
    do_abort();
    configure(4'b1011, 1'b1, 8'd0, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] pv;
      pv = 4'b1011;
      bit_in(pv[i], 1'b0);
      check(i == 0 ? "t4_pulse" : "t4_nopulse", int'(out), i == 0 ? 1 : 0);
      cycle();
      check("t4_gap", int'(out), 0);
      cycle();
    end

    // 1111 + start in one cycle, six ones: three consecutive pulses
    do_abort();
    configure(4'b1111, 1'b1, 8'd0, 1'b1);
    stream(16'b111, 3);
    for (int i = 0; i < 3; i++) begin
      bit_in(1'b1, 1'b0);
      check("t5_out", int'(out), 1);
    end
    check("t5_cnt", int'(match_cnt), 3);

    // abort on a matching bit discards that match
    do_abort();
    configure(4'b1011, 1'b1, 8'd0, 1'b1);
    stream(16'b1011_101, 7);
    bit_in(1'b1, 1'b1);
    check("t6_out", int'(out), 0);
    check("t6_cnt", int'(match_cnt), 1);
    check("t6_idle", int'(cfg_ready), 1);

    // config attempt during a run is ignored
    configure(4'b0110, 1'b0, 8'd3, 1'b1);
    configure(4'b0000, 1'b1, 8'd1, 1'b0);
    check("t7_ready", int'(cfg_ready), 0);
    stream(16'b0110, 4);
    check("t7_out", int'(out), 1);
    check("t7_done", int'(done), 0);

    // reset mid-run restores defaults, including the 1011 pattern
    stream(16'b01, 2);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("t8_busy", int'(busy), 0);
    check("t8_cnt", int'(match_cnt), 0);
    check("t8_ready", int'(cfg_ready), 1);
    do_start();
    stream(16'b1011, 4);
    check("t8_default", int'(out), 1);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      cfg_valid   = ($urandom_range(0, 9) == 0);
      cfg_pattern = 4'($urandom);
      cfg_overlap = 1'($urandom);
      cfg_limit   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      start       = ($urandom_range(0, 19) == 0);
      abort       = ($urandom_range(0, 79) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      in          = 1'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Programmable controller wrapped around a Moore 4-bit serial sequence detector. It accepts a pattern, overlap mode and match limit through a ready/valid configuration port. It then sequences a detection run on a qualified serial bit stream, counts matches and signals completion. It replaces hard-wired single-pattern detectors wherever a stream monitor must be retargeted at run time.

## Interface
- No parameters; pattern width fixed at 4, counter width fixed at 8.
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  high only in IDLE; transfer when cfg_valid && cfg_ready
- cfg_pattern  in  4  target sequence, MSB = oldest bit
- cfg_overlap  in  1  1 = overlapping matches allowed
- cfg_limit  in  8  matches before DONE; 0 = unlimited
- start  in  1  begin run (IDLE or DONE)
- abort  in  1  terminate run, return to IDLE
- in  in  1  serial data bit
- in_valid  in  1  bit qualifier; bits sampled only in RUN with in_valid=1
- out  out  1  Moore match flag, one cycle per match
- match_cnt  out  8  matches in current run, saturates at 255
- busy  out  1  high in RUN
- done  out  1  high in DONE

## Operation
- States:
  - IDLE: cfg_ready=1, stream ignored.
  - RUN: shift history, compare, count.
  - DONE: stream ignored, match_cnt held.
- Transitions:
  - IDLE --start--> RUN
  - RUN --limit reached--> DONE
  - RUN --abort--> IDLE
  - DONE --start--> RUN
  - DONE --abort--> IDLE
- abort has priority over start and over a same-cycle match. The matching bit's match is discarded: out stays 0 and match_cnt is not incremented.
- Config registers (pattern, overlap, limit) load only on a cfg handshake in IDLE.
  - Reset values: pattern=4'b1011, overlap=1, limit=0.
  - cfg_valid while cfg_ready=0: ignored, no stall required from the requester.
- Config and start in the same IDLE cycle: the config is captured, and the run uses the new values.
- Entering RUN clears the 4-bit history register, its 3-bit fill counter (0..4) and match_cnt.
- Each accepted bit shifts into the LSB of the history register; the fill counter increments, saturating at 4.
- Match condition: fill counter reaches 4 and the updated history equals pattern.
- On a match:
  - overlap=1: history and fill are retained.
  - overlap=0: the fill counter is cleared to 0, so the next match needs 4 fresh bits.
- match_cnt increments per match, saturating at 255.
- If limit≠0 and the incremented count equals limit, the state moves to DONE.
- A start in DONE restarts a run with the current config and clears match_cnt.

## Timing
- Reset values: state=IDLE, out=0, match_cnt=0, busy=0, done=0, cfg_ready=1, history=0, fill=0.
- Match latency: for the final pattern bit sampled at edge E, out=1 in the cycle following E.
  - match_cnt shows the incremented value in the same cycle.
  - out returns to 0 at E+1 unless a new match occurs at E+1.
- Back-to-back matches (overlap, e.g. pattern 1111 on a stream of ones) keep out high on consecutive cycles.
- Limit reached at edge E: in the cycle after E, out=1, done=1, busy=0.
- start sampled at edge S: busy=1 from cycle S+1; the first bit is sampled at S+1 at the earliest.
- Cycles with in_valid=0 in RUN: history, fill, out=0 and count all held.
- rst mid-run: all state returns to reset values at that edge; config reverts to defaults.

## Test plan
- Reset defaults, then start. Stream 1,0,1,1,0,1,1 with in_valid=1 -> out pulses after bits 4 and 7; match_cnt=2; done=0.
- Config handshake loading pattern 1011, overlap=0. Same stream -> only one pulse after bit 4; match_cnt=1.
- Config limit=2, overlap=1. Stream 1,0,1,1,1,0,1,1 -> pulses after bits 4 and 8; done=1 with match_cnt=2 in the cycle after bit 8. Further bits ignored; start restarts with match_cnt=0.
- Stream 1,0,1,1 with in_valid=0 gap cycles between bits -> exactly one pulse, one cycle after the 4th valid bit; no pulse during gaps.
- Config 1111 plus start in the same cycle, then six 1s -> out high for 3 consecutive cycles; match_cnt=3.
- Edge cases:
  - abort asserted with the 4th matching bit -> IDLE, out=0, match_cnt unchanged.
  - cfg_valid during RUN -> cfg_ready=0 and config unchanged.
  - rst mid-run -> all outputs at reset values next cycle.
